// File: rtl/play_speed_pkg.sv
// Shared types and constants for the playback rate stage: FSM states and
// the 1/F reciprocal table used by the optional interpolator.
package play_speed_pkg;

  typedef enum logic {
    FETCH,
    EMIT
  } state_t;

  localparam int RECIP_SHIFT = 12;
  localparam int RECIP_W     = 13;

  // round(4096 / F), indexed by F-1
  function automatic logic [RECIP_W-1:0] recip_of(input logic [2:0] speed);
    logic [RECIP_W-1:0] r;
    r = 13'd4096;
    case (speed)
      3'd0: r = 13'd4096;
      3'd1: r = 13'd2048;
      3'd2: r = 13'd1365;
      3'd3: r = 13'd1024;
      3'd4: r = 13'd819;
      3'd5: r = 13'd683;
      3'd6: r = 13'd585;
      3'd7: r = 13'd512;
      default: r = 13'd4096;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/play_speed_interp.sv
// Combinational linear interpolator: p + ((c - p) * k * RECIP[F]) >>> 12,
// saturated to the signed sample range.
module play_speed_interp
  import play_speed_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic [SAMPLE_W-1:0] i_prev,
  input  logic [SAMPLE_W-1:0] i_cur,
  input  logic [2:0]          i_phase,
  input  logic [2:0]          i_speed,
  output logic [SAMPLE_W-1:0] o_sample
);

  localparam int PW = 2 * SAMPLE_W + 2;

  logic signed [PW-1:0] prev_ext;
  logic signed [PW-1:0] diff;
  logic signed [PW-1:0] phase_ext;
  logic signed [PW-1:0] recip_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sum;

  assign prev_ext  = {{(PW-SAMPLE_W){i_prev[SAMPLE_W-1]}}, i_prev};
  assign diff      = {{(PW-SAMPLE_W){i_cur[SAMPLE_W-1]}}, i_cur} - prev_ext;
  assign phase_ext = {{(PW-3){1'b0}}, i_phase};
  assign recip_ext = {{(PW-RECIP_W){1'b0}}, recip_of(i_speed)};
  assign prod      = diff * phase_ext * recip_ext;
  assign sum       = prev_ext + (prod >>> RECIP_SHIFT);

  // Saturate when the upper bits are not a pure sign extension
  always_comb begin
    o_sample = sum[SAMPLE_W-1:0];
    if (sum[PW-1:SAMPLE_W-1] != {(PW-SAMPLE_W+1){sum[PW-1]}})
      o_sample = sum[PW-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                           : {1'b0, {(SAMPLE_W-1){1'b1}}};
  end

endmodule

// File: rtl/play_speed_ctrl.sv
// Playback rate stage: splits 32-bit words into two samples and decimates or
// repeats them. Define PLAY_SPEED_INTERP_EN for interpolated slow mode.
module play_speed_ctrl #(
  parameter int SAMPLE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [2:0]            i_speed,
  input  logic                  i_slow,
  input  logic [2*SAMPLE_W-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic [SAMPLE_W-1:0]   o_sample,
  output logic                  o_sample_valid,
  input  logic                  i_sample_ready,
  output logic                  o_busy
);

  import play_speed_pkg::*;

  state_t                state_q, state_d;
  logic [2*SAMPLE_W-1:0] word_q, word_d;
  logic                  idx_q, idx_d;
  logic [2:0]            speed_q, speed_d;
  logic                  slow_q, slow_d;
  logic [2:0]            skip_q, skip_d;
  logic [2:0]            phase_q, phase_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  done;
  logic                  can_load;
  logic [SAMPLE_W-1:0]   cur;
  logic [SAMPLE_W-1:0]   slow_val;

  assign cur      = idx_q ? word_q[SAMPLE_W-1:0] : word_q[2*SAMPLE_W-1:SAMPLE_W];
  assign can_load = !valid_q || i_sample_ready;

`ifdef PLAY_SPEED_INTERP_EN
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                have_prev_q, have_prev_d;
  logic [SAMPLE_W-1:0] prev_eff;

  // Without history the first sample interpolates against itself
  assign prev_eff = have_prev_q ? prev_q : cur;

  play_speed_interp #(
    .SAMPLE_W (SAMPLE_W)
  ) u_interp (
    .i_prev   (prev_eff),
    .i_cur    (cur),
    .i_phase  (phase_q),
    .i_speed  (speed_q),
    .o_sample (slow_val)
  );

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    if (done) begin
      prev_d      = cur;
      have_prev_d = 1'b1;
    end
    if (i_flush) have_prev_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end
`else
  assign slow_val = cur;
`endif

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    speed_d  = speed_q;
    slow_d   = slow_q;
    skip_d   = skip_q;
    phase_d  = phase_q;
    sample_d = sample_q;
    valid_d  = valid_q && !i_sample_ready;
    done     = 1'b0;
    case (state_q)
      FETCH: begin
        if (i_word_valid && !i_flush) begin
          word_d  = i_word;
          idx_d   = 1'b0;
          speed_d = i_speed;
          slow_d  = i_slow;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (slow_q) begin
          if (can_load) begin
            sample_d = slow_val;
            valid_d  = 1'b1;
            if (phase_q == speed_q) begin
              phase_d = '0;
              done    = 1'b1;
            end else begin
              phase_d = phase_q + 3'd1;
            end
          end
        end else if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
          done   = 1'b1;
        end else if (can_load) begin
          sample_d = cur;
          valid_d  = 1'b1;
          skip_d   = speed_q;
          done     = 1'b1;
        end
        if (done) begin
          if (idx_q) state_d = FETCH;
          else       idx_d   = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
    // Flush overrides every handshake decided above
    if (i_flush) begin
      state_d = FETCH;
      skip_d  = '0;
      phase_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= FETCH;
      word_q   <= '0;
      idx_q    <= 1'b0;
      speed_q  <= '0;
      slow_q   <= 1'b0;
      skip_q   <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      speed_q  <= speed_d;
      slow_q   <= slow_d;
      skip_q   <= skip_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign o_sample       = sample_q;
  assign o_sample_valid = valid_q;
  assign o_word_ready   = (state_q == FETCH) && !i_flush;
  assign o_busy         = (state_q != FETCH) || valid_q;

endmodule
